// File: rtl/draw_arbiter.sv
// Two-requester framebuffer write-port arbiter with round-robin tie break and one-cycle turnaround gap.
// Optional watchdog revocation of stuck owners is enabled by defining DRAW_ARB_WATCHDOG_EN.
module draw_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic       we0,
  input  logic       we1,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [8:0] y0,
  input  logic [8:0] y1,
  input  logic       bnw0,
  input  logic       bnw1,
  output logic [1:0] grant,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       blackNotWhite,
  output logic       write,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] fsm_state
);

  // Protocol: a requester holds req[n] for its whole burst; we[n] is a pixel strobe
  // honoured only while it owns the port; done[n] (or dropping req[n]) ends the burst.
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, GAP = 2'd3} state_t;

  state_t state, state_next;
  logic   last_owner, last_owner_next;
  logic   wd_expire;
  logic   revoke;

`ifdef DRAW_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] watchdog;

  // Counter is zero during the first owned cycle, so expiry lands on the TIMEOUT-th one.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      watchdog <= '0;
    end else if (state == OWN0 || state == OWN1) begin
      watchdog <= watchdog + WD_W'(1);
    end else begin
      watchdog <= '0;
    end
  end

  assign wd_expire = (watchdog == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    revoke          = 1'b0;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_next = OWN0;
          2'b10:   state_next = OWN1;
          2'b11:   state_next = last_owner ? OWN0 : OWN1;
          default: state_next = IDLE;
        endcase
        if (state_next == OWN0) last_owner_next = 1'b0;
        if (state_next == OWN1) last_owner_next = 1'b1;
      end
      OWN0: begin
        if (done[0] || !req[0]) begin
          state_next = GAP;
        end else if (wd_expire) begin
          state_next = GAP;
          revoke     = 1'b1;
        end
      end
      OWN1: begin
        if (done[1] || !req[1]) begin
          state_next = GAP;
        end else if (wd_expire) begin
          state_next = GAP;
          revoke     = 1'b1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // grant lags the state by one cycle so it lines up with the registered write port.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      grant         <= 2'b00;
      write         <= 1'b0;
      x             <= '0;
      y             <= '0;
      blackNotWhite <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      grant      <= {state == OWN1, state == OWN0};
      timeout    <= revoke;
      write      <= 1'b0;
      if (state == OWN0 && we0) begin
        write         <= 1'b1;
        x             <= x0;
        y             <= y0;
        blackNotWhite <= bnw0;
      end else if (state == OWN1 && we1) begin
        write         <= 1'b1;
        x             <= x1;
        y             <= y1;
        blackNotWhite <= bnw1;
      end
    end
  end

  assign busy      = |grant;
  assign fsm_state = state;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: vector table for the main sequence plus hand-written
// sequences for round-robin bursts, watchdog (DRAW_ARB_WATCHDOG_EN) and mid-burst reset.
module tb_draw_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] req, done;
  logic       we0, we1, bnw0, bnw1;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [1:0] grant;
  logic [9:0] x;
  logic [8:0] y;
  logic       blackNotWhite, write, busy, timeout;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];

  draw_arbiter #(.TIMEOUT(8)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .done(done),
    .we0(we0), .we1(we1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .bnw0(bnw0), .bnw1(bnw1), .grant(grant), .x(x), .y(y),
    .blackNotWhite(blackNotWhite), .write(write), .busy(busy),
    .timeout(timeout), .fsm_state(fsm_state)
  );

  // clock / global time limit
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation exceeded bound");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [1:0] req, done;
    logic       we0; logic [9:0] x0; logic [8:0] y0; logic bnw0;
    logic       we1; logic [9:0] x1; logic [8:0] y1; logic bnw1;
    logic [1:0] g; logic w; logic [9:0] ex; logic [8:0] ey; logic eb;
  } vec_t;

  function automatic vec_t mk(input int rq, input int dn,
                              input int w0, input int a0, input int b0, input int c0,
                              input int w1, input int a1, input int b1, input int c1,
                              input int g, input int w, input int ex, input int ey, input int eb);
    vec_t v;
    v.req = 2'(rq); v.done = 2'(dn);
    v.we0 = 1'(w0); v.x0 = 10'(a0); v.y0 = 9'(b0); v.bnw0 = 1'(c0);
    v.we1 = 1'(w1); v.x1 = 10'(a1); v.y1 = 9'(b1); v.bnw1 = 1'(c1);
    v.g = 2'(g); v.w = 1'(w); v.ex = 10'(ex); v.ey = 9'(ey); v.eb = 1'(eb);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; done = 2'b00;
    we0 = 1'b0; we1 = 1'b0; bnw0 = 1'b0; bnw1 = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
  endtask

  vec_t vt[14];

  initial begin
    // main sequence: rows are inputs for one cycle and outputs expected after its edge
    vt[0]  = mk(1, 0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0,   0,  0, 0);
    vt[1]  = mk(1, 0, 1,  10, 20, 1, 0,   0,  0, 0, 1, 1,  10, 20, 1);
    vt[2]  = mk(1, 0, 0,   0,  0, 0, 1, 300,  5, 0, 1, 0,  10, 20, 1);
    vt[3]  = mk(3, 1, 1, 261,  1, 0, 1, 300,  5, 0, 1, 1, 261,  1, 0);
    vt[4]  = mk(3, 0, 1,   5,  5, 1, 1, 300,  5, 0, 0, 0, 261,  1, 0);
    vt[5]  = mk(3, 0, 0,   0,  0, 0, 1, 100, 50, 1, 0, 0, 261,  1, 0);
    vt[6]  = mk(3, 0, 1, 300,  9, 1, 1, 100, 50, 1, 2, 1, 100, 50, 1);
    vt[7]  = mk(1, 0, 0,   0,  0, 0, 1, 101, 51, 0, 2, 1, 101, 51, 0);
    vt[8]  = mk(1, 0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0, 101, 51, 0);
    vt[9]  = mk(1, 0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0, 101, 51, 0);
    vt[10] = mk(1, 2, 1,   7,  8, 1, 0,   0,  0, 0, 1, 1,   7,  8, 1);
    vt[11] = mk(0, 0, 0,   0,  0, 0, 0,   0,  0, 0, 1, 0,   7,  8, 1);
    vt[12] = mk(0, 0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0,   7,  8, 1);
    vt[13] = mk(0, 0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0,   7,  8, 1);

    // reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_write", write, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_bnw", blackNotWhite, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", fsm_state, 0);

    for (int i = 0; i < 14; i++) begin
      req = vt[i].req; done = vt[i].done;
      we0 = vt[i].we0; x0 = vt[i].x0; y0 = vt[i].y0; bnw0 = vt[i].bnw0;
      we1 = vt[i].we1; x1 = vt[i].x1; y1 = vt[i].y1; bnw1 = vt[i].bnw1;
      step();
      check($sformatf("vec%0d_grant", i), grant, vt[i].g);
      check($sformatf("vec%0d_write", i), write, vt[i].w);
      check($sformatf("vec%0d_x", i), x, vt[i].ex);
      check($sformatf("vec%0d_y", i), y, vt[i].ey);
      check($sformatf("vec%0d_bnw", i), blackNotWhite, vt[i].eb);
      check($sformatf("vec%0d_busy", i), busy, (vt[i].g != 2'b00));
      check($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // round-robin bursts of 4 writes each, req=11 held
    begin
      int cnt[2];
      bit sent[2];
      int wr_cnt;
      int both;
      logic [1:0] last_g;
      do_reset();
      req = 2'b11;
      exp_q = {2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      last_g = 2'b00; wr_cnt = 0; both = 0;
      cnt[0] = 0; cnt[1] = 0; sent[0] = 0; sent[1] = 0;
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
        if (write) wr_cnt++;
        if (grant == 2'b11) both++;
        if (grant != last_g) begin
          check("rr_grant_seq", grant, exp_q.pop_front());
          last_g = grant;
        end
        done = 2'b00; we0 = 1'b0; we1 = 1'b0;
        for (int n = 0; n < 2; n++) begin
          if (grant[n] && !sent[n]) begin
            if (n == 0) begin we0 = 1'b1; x0 = 10'(cnt[0]); end
            else        begin we1 = 1'b1; x1 = 10'(cnt[1]); end
            cnt[n]++;
            if (cnt[n] == 4) begin
              done[n] = 1'b1;
              sent[n] = 1'b1;
            end
          end
          if (!grant[n]) begin
            cnt[n] = 0;
            sent[n] = 0;
          end
        end
        step();
      end
      check("rr_seq_complete", exp_q.size(), 0);
      check("rr_write_count", wr_cnt, 8);
      check("rr_never_both", both, 0);
    end

`ifdef DRAW_ARB_WATCHDOG_EN
    // watchdog revokes requester 0 after 8 owned cycles, then requester 1 gets the port
    begin
      int run, pulses;
      bit got1;
      do_reset();
      req = 2'b11;
      run = 0; pulses = 0; got1 = 0;
      for (int cyc = 0; cyc < 60 && !got1; cyc++) begin
        if (grant == 2'b01) run++;
        if (timeout) pulses++;
        if (grant == 2'b10) got1 = 1;
        step();
      end
      check("wd_owned_cycles", run, 8);
      check("wd_timeout_pulses", pulses, 1);
      check("wd_req1_granted", got1, 1);
    end
`else
    // without the watchdog a held request keeps the port indefinitely
    begin
      int run, pulses;
      do_reset();
      req = 2'b01;
      run = 0; pulses = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        step();
        if (grant == 2'b01) run++;
        if (timeout) pulses++;
      end
      check("nowd_hold_cycles", run, 59);
      check("nowd_timeout_pulses", pulses, 0);
    end
`endif

    // reset in the middle of an OWN1 burst
    do_reset();
    req = 2'b10; we1 = 1'b1; x1 = 10'd55; y1 = 9'd66; bnw1 = 1'b1;
    step();
    step();
    check("mid_pre_grant", grant, 2'b10);
    check("mid_pre_write", write, 1);
    check("mid_pre_x", x, 55);
    Reset = 1'b0;
    step();
    check("mid_rst_grant", grant, 0);
    check("mid_rst_write", write, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_bnw", blackNotWhite, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", timeout, 0);
    Reset = 1'b1;
    req = 2'b11; we1 = 1'b0;
    step();
    check("mid_rel_grant_gap", grant, 0);
    step();
    check("mid_rel_grant_req0", grant, 2'b01);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
